// File: rtl/l2_writeback_buffer.sv
// l2_writeback_buffer: victim write-back FIFO between the L2 data array and
// physical memory. Dirty lines are queued, drained in order over the pmem
// handshake, and snooped by L2 miss lookups so a refill never reads stale memory.
module l2_writeback_buffer #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 256,
  parameter int AW    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_valid,
  input  logic [AW-1:0]    wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic             wb_ready,
  output logic             pmem_write,
  output logic [AW-1:0]    pmem_address,
  output logic [WIDTH-1:0] pmem_wdata,
  input  logic             pmem_resp,
  input  logic [AW-1:0]    snoop_addr,
  output logic             snoop_hit,
  output logic [WIDTH-1:0] snoop_data,
  output logic             empty,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = AW - 5;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef struct packed {
    logic             vld;
    logic [TW-1:0]    tag;
    logic [WIDTH-1:0] data;
  } entry_t;

  typedef enum logic {IDLE, WRITE} state_t;

  entry_t        ent [DEPTH];
  logic [PW-1:0] head, tail;
  logic [PW:0]   count;
  state_t        state, state_nxt;
  logic          push, pop;

  // Line offset bits carry no information for a line-granular buffer.
  logic unused_offs;
  assign unused_offs = ^{wb_addr[4:0], snoop_addr[4:0]};

  // Acceptance depends on occupancy only, so a same-cycle pop never opens a slot.
  assign wb_ready = (count != FULL_CNT);
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign push     = wb_valid & wb_ready;
  assign pop      = (state == WRITE) & pmem_resp;

  // Entry storage: push fills the tail slot, pop invalidates the head slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && tail == PW'(i)) begin
          ent[i].vld  <= 1'b1;
          ent[i].tag  <= wb_addr[AW-1:5];
          ent[i].data <= wb_data;
        end else if (pop && head == PW'(i)) begin
          ent[i].vld  <= 1'b0;
        end
      end
    end
  end

  // Circular pointers and occupancy counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Drain FSM state register; reset drops an in-flight write immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Drain FSM next state and pmem outputs; returning to IDLE forces one bubble.
  always_comb begin
    state_nxt    = state;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    case (state)
      IDLE: begin
        if (count != '0) state_nxt = WRITE;
      end
      WRITE: begin
        pmem_write   = 1'b1;
        pmem_address = {ent[head].tag, 5'b0};
        pmem_wdata   = ent[head].data;
        if (pmem_resp) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Snoop: walk oldest to newest so the last match (newest line) wins.
  always_comb begin
    logic [PW-1:0] idx;
    snoop_hit  = 1'b0;
    snoop_data = '0;
    idx        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (ent[idx].vld && ent[idx].tag == snoop_addr[AW-1:5]) begin
        snoop_hit  = 1'b1;
        snoop_data = ent[idx].data;
      end
    end
  end

endmodule

// File: tb/tb_l2_writeback_buffer.sv
// tb_l2_writeback_buffer: scenario tasks plus a randomized run against a
// queue-based model of the write-back buffer.
module tb_l2_writeback_buffer;

  localparam int DEPTH = 2;
  localparam int WIDTH = 256;
  localparam int AW    = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wb_valid;
  logic [AW-1:0]    wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic             wb_ready;
  logic             pmem_write;
  logic [AW-1:0]    pmem_address;
  logic [WIDTH-1:0] pmem_wdata;
  logic             pmem_resp;
  logic [AW-1:0]    snoop_addr;
  logic             snoop_hit;
  logic [WIDTH-1:0] snoop_data;
  logic             empty;
  logic             full;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } line_t;

  l2_writeback_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
    .pmem_write(pmem_write), .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp),
    .snoop_addr(snoop_addr), .snoop_hit(snoop_hit), .snoop_data(snoop_data),
    .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] rnd_line();
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Push one line across the next posedge; caller guarantees room.
  task automatic push_line(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    wb_valid = 1'b1;
    wb_addr  = a;
    wb_data  = d;
    @(negedge clk);
    wb_valid = 1'b0;
  endtask

  // Wait (bounded) for pmem_write at a negedge.
  task automatic wait_write(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (pmem_write) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  // Acknowledge the current write for one cycle.
  task automatic ack();
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    rst_n = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    pmem_resp = 1'b0; snoop_addr = '0;
    #1;
    checks++;
    if (pmem_write !== 1'b0 || empty !== 1'b1 || full !== 1'b0 || wb_ready !== 1'b1 ||
        snoop_hit !== 1'b0 || pmem_address !== '0 || snoop_data !== '0) begin
      errors++;
      $display("FAIL reset_state: write=%b empty=%b full=%b ready=%b hit=%b required 0 1 0 1 0",
               pmem_write, empty, full, wb_ready, snoop_hit);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_line(32'h0000_0AC0, rnd_line());
    wait_write(10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_prewrite: no pmem_write, required 1"); end
    snoop_addr = 32'h0000_0AC0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pmem_write !== 1'b0 || empty !== 1'b1 || full !== 1'b0 || wb_ready !== 1'b1 ||
        snoop_hit !== 1'b0) begin
      errors++;
      $display("FAIL reset_midwrite: write=%b empty=%b full=%b ready=%b hit=%b required 0 1 0 1 0",
               pmem_write, empty, full, wb_ready, snoop_hit);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (pmem_write !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_discard: write=%b empty=%b required 0 1", pmem_write, empty);
    end
  endtask

  task automatic test_single();
    logic [WIDTH-1:0] d;
    d = {8{32'hDEADBEEF}};
    push_line(32'h0000_1234, d);
    checks++;
    if (pmem_write !== 1'b0 || empty !== 1'b0) begin
      errors++;
      $display("FAIL single_lat1: write=%b empty=%b required 0 0", pmem_write, empty);
    end
    @(negedge clk);
    checks++;
    if (pmem_write !== 1'b1 || pmem_address !== 32'h0000_1220 || pmem_wdata !== d) begin
      errors++;
      $display("FAIL single_write: write=%b addr=%h required 1 00001220 (data ok=%b)",
               pmem_write, pmem_address, pmem_wdata === d);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (pmem_write !== 1'b1 || pmem_address !== 32'h0000_1220 || pmem_wdata !== d) begin
        errors++;
        $display("FAIL single_hold: write=%b addr=%h required 1 00001220", pmem_write, pmem_address);
      end
    end
    ack();
    checks++;
    if (empty !== 1'b1 || pmem_write !== 1'b0) begin
      errors++;
      $display("FAIL single_done: empty=%b write=%b required 1 0", empty, pmem_write);
    end
  endtask

  task automatic test_full();
    logic [AW-1:0]    ea [3];
    logic [WIDTH-1:0] ed [3];
    bit ok;
    ea = '{32'h100, 32'h200, 32'h300};
    for (int i = 0; i < 3; i++) ed[i] = rnd_line();
    push_line(ea[0], ed[0]);
    push_line(ea[1], ed[1]);
    checks++;
    if (full !== 1'b1 || wb_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_flags: full=%b ready=%b required 1 0", full, wb_ready);
    end
    wb_valid = 1'b1; wb_addr = ea[2]; wb_data = ed[2];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (wb_ready !== 1'b0 || full !== 1'b1) begin
        errors++;
        $display("FAIL full_hold: ready=%b full=%b required 0 1", wb_ready, full);
      end
    end
    wait_write(5, ok);
    checks++;
    if (!ok || pmem_address !== ea[0] || pmem_wdata !== ed[0]) begin
      errors++;
      $display("FAIL full_first: ok=%b addr=%h required 1 %h", ok, pmem_address, ea[0]);
    end
    ack();
    checks++;
    if (wb_ready !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL full_reopen: ready=%b full=%b required 1 0", wb_ready, full);
    end
    @(negedge clk);
    wb_valid = 1'b0;
    for (int i = 1; i < 3; i++) begin
      wait_write(10, ok);
      checks++;
      if (!ok || pmem_address !== ea[i] || pmem_wdata !== ed[i]) begin
        errors++;
        $display("FAIL full_order%0d: ok=%b addr=%h required 1 %h", i, ok, pmem_address, ea[i]);
      end
      ack();
    end
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL full_empty: empty=%b required 1", empty); end
  endtask

  task automatic test_snoop();
    logic [WIDTH-1:0] da, db;
    bit ok;
    da = rnd_line(); db = rnd_line();
    push_line(32'h40, da);
    push_line(32'h5F, db);
    snoop_addr = 32'h44;
    #1;
    checks++;
    if (snoop_hit !== 1'b1 || snoop_data !== db) begin
      errors++;
      $display("FAIL snoop_newest: hit=%b newest=%b required 1 1", snoop_hit, snoop_data === db);
    end
    snoop_addr = 32'h60;
    #1;
    checks++;
    if (snoop_hit !== 1'b0 || snoop_data !== '0) begin
      errors++;
      $display("FAIL snoop_miss: hit=%b required 0", snoop_hit);
    end
    snoop_addr = 32'h44;
    for (int i = 0; i < 2; i++) begin
      wait_write(10, ok);
      checks++;
      if (!ok || pmem_address !== 32'h40 || pmem_wdata !== (i == 0 ? da : db)) begin
        errors++;
        $display("FAIL snoop_drain%0d: ok=%b addr=%h required 1 00000040", i, ok, pmem_address);
      end
      ack();
      #1;
      checks++;
      if (snoop_hit !== (i == 0) || snoop_data !== (i == 0 ? db : '0)) begin
        errors++;
        $display("FAIL snoop_after_pop%0d: hit=%b required %0d", i, snoop_hit, i == 0);
      end
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0]    la [3*DEPTH+1];
    logic [WIDTH-1:0] ld [3*DEPTH+1];
    bit ok;
    for (int i = 0; i <= 3*DEPTH; i++) begin
      la[i] = 32'h2000 + (i << 5);
      ld[i] = rnd_line();
    end
    push_line(la[0], ld[0]);
    for (int k = 0; k < 3*DEPTH; k++) begin
      wait_write(10, ok);
      checks++;
      if (!ok || pmem_address !== la[k] || pmem_wdata !== ld[k]) begin
        errors++;
        $display("FAIL wrap_order%0d: ok=%b addr=%h required 1 %h", k, ok, pmem_address, la[k]);
      end
      wb_valid = 1'b1; wb_addr = la[k+1]; wb_data = ld[k+1];
      pmem_resp = 1'b1;
      @(negedge clk);
      wb_valid = 1'b0; pmem_resp = 1'b0;
      checks++;
      if (empty !== 1'b0 || full !== 1'b0) begin
        errors++;
        $display("FAIL wrap_count%0d: empty=%b full=%b required 0 0", k, empty, full);
      end
    end
    wait_write(10, ok);
    checks++;
    if (!ok || pmem_address !== la[3*DEPTH] || pmem_wdata !== ld[3*DEPTH]) begin
      errors++;
      $display("FAIL wrap_last: ok=%b addr=%h required 1 %h", ok, pmem_address, la[3*DEPTH]);
    end
    ack();
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: empty=%b required 1", empty); end
  endtask

  // Model: ordered queue of accepted lines; a write completes when pmem_write
  // and pmem_resp coincide at an edge; snoop returns the last matching line.
  task automatic test_random();
    line_t q[$];
    line_t ln;
    int pushed = 0, written = 0, waited = 0, lat, cyc = 0;
    bit exp_hit, do_pop, do_push;
    logic [WIDTH-1:0] exp_data;
    lat = $urandom_range(1, 20);
    while (cyc < 3000 && (cyc < 400 || q.size() != 0)) begin
      cyc++;
      if ($urandom_range(0, 1) == 1 && q.size() != 0)
        snoop_addr = q[$urandom_range(0, q.size()-1)].addr | 32'($urandom_range(0, 31));
      else
        snoop_addr = 32'h8000 + ($urandom_range(0, 7) << 5) + $urandom_range(0, 31);
      #1;
      exp_hit = 1'b0; exp_data = '0;
      foreach (q[i])
        if (q[i].addr[AW-1:5] == snoop_addr[AW-1:5]) begin exp_hit = 1'b1; exp_data = q[i].data; end
      checks++;
      if (snoop_hit !== exp_hit || snoop_data !== exp_data) begin
        errors++;
        $display("FAIL rnd_snoop: addr=%h hit=%b required %b", snoop_addr, snoop_hit, exp_hit);
      end
      checks++;
      if (empty !== (q.size() == 0) || full !== (q.size() == DEPTH) || wb_ready !== (q.size() != DEPTH)) begin
        errors++;
        $display("FAIL rnd_flags: empty=%b full=%b ready=%b model_count=%0d", empty, full, wb_ready, q.size());
      end
      if (pmem_write) begin
        checks++;
        if (q.size() == 0 || pmem_address !== q[0].addr || pmem_wdata !== q[0].data) begin
          errors++;
          $display("FAIL rnd_write: addr=%h required %h (model_count=%0d)", pmem_address,
                   q.size() ? q[0].addr : 32'h0, q.size());
        end
        waited++;
      end
      do_pop = pmem_write && waited >= lat;
      pmem_resp = do_pop ? 1'b1 : (!pmem_write && $urandom_range(0, 7) == 0);
      do_push = cyc < 400 && $urandom_range(0, 2) != 0;
      wb_valid = do_push;
      ln.addr = 32'h8000 + ($urandom_range(0, 7) << 5);
      ln.data = rnd_line();
      wb_addr = ln.addr | 32'($urandom_range(0, 31));
      wb_data = ln.data;
      if (do_pop) begin
        void'(q.pop_front());
        written++;
        waited = 0;
        lat = $urandom_range(1, 20);
      end
      if (do_push && (q.size() + (do_pop ? 1 : 0)) < DEPTH) begin
        q.push_back(ln);
        pushed++;
      end
      @(negedge clk);
    end
    wb_valid = 1'b0; pmem_resp = 1'b0;
    checks++;
    if (q.size() != 0 || pushed != written || written == 0) begin
      errors++;
      $display("FAIL rnd_complete: pushed=%0d written=%0d left=%0d required all written", pushed, written, q.size());
    end
    @(negedge clk);
    checks++;
    if (empty !== 1'b1 || pmem_write !== 1'b0) begin
      errors++;
      $display("FAIL rnd_final: empty=%b write=%b required 1 0", empty, pmem_write);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_snoop();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
